// File: rtl/zxd_pkg.sv
// zxd_pkg: shared SRAM constants and upload FSM states for the download/upload paths
package zxd_pkg;
  localparam int SRAM_AW = 15;
  localparam int SETTLE_DEF = 2;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} upState_t;
endpackage

// File: rtl/sram_window.sv
// sram_window: marks the two-clock video fetch window and captures the video byte at its end
module sram_window (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] sramD,
  output logic       win,
  output logic [7:0] vidQ
);
  logic ceD;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ceD <= 1'b0;
      vidQ <= '0;
    end else begin
      ceD <= ce;
      if (ceD) vidQ <= sramD;
    end
  assign win = ce | ceD;
endmodule

// File: rtl/sram_upload.sv
// sram_upload: host read-back of SRAM in the gaps between video fetches (video has priority).
// Optional UPLOAD_CHECKSUM_EN adds a running 16-bit sum of uploaded bytes on upSum.
module sram_upload
  import zxd_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic [AW-1:0] vidA,
  output logic [7:0]    vidQ,
  input  logic          upActive,
  input  logic          upRd,
  input  logic [AW-1:0] upA,
  output logic [7:0]    upQ,
  output logic          upValid,
  output logic          upBusy,
  output logic [AW-1:0] sramA,
  output logic          sramOe,
  input  logic [7:0]    sramD
`ifdef UPLOAD_CHECKSUM_EN
  , output logic [15:0] upSum
`endif
);
  localparam int CW = $clog2(SETTLE) + 1;
  upState_t state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] upAr;
  logic win;
  sram_window uWin (.clock(clock), .reset(reset), .ce(ce), .sramD(sramD), .win(win), .vidQ(vidQ));
  assign sramA = (state == ACCESS && !win) ? upAr : vidA;
  assign upValid = state == DONE;
  // any video window restarts the settle count: the address must be stable for SETTLE free clocks
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      upAr <= '0;
      upQ <= '0;
      upBusy <= 1'b0;
      sramOe <= 1'b1;
    end else begin
      sramOe <= 1'b0;
      case (state)
        IDLE: if (upRd && upActive) begin
          upAr <= upA;
          upBusy <= 1'b1;
          cnt <= '0;
          state <= ACCESS;
        end
        ACCESS: if (!upActive) begin
          state <= IDLE;
          upBusy <= 1'b0;
        end else if (win) cnt <= '0;
        else if (cnt == CW'(SETTLE - 1)) begin
          upQ <= sramD;
          state <= DONE;
        end else cnt <= cnt + CW'(1);
        default: begin
          upBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
`ifdef UPLOAD_CHECKSUM_EN
  logic actD;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      actD <= 1'b0;
      upSum <= '0;
    end else begin
      actD <= upActive;
      if (upActive && !actD) upSum <= '0;
      else if (upValid) upSum <= upSum + {8'h00, upQ};
    end
`endif
endmodule
